// File: rtl/fx2_slave_fifo_model.sv
// FX2 slave-FIFO endpoint pair with explicit packet commit: host words reach FD only
// after commit, FPGA words reach the host stream only after auto-commit or PKTEND.
module fx2_slave_fifo_model #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 512,
   parameter int PKT_WORDS = 256,
   parameter int EP_RD     = 2,
   parameter int EP_WR     = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   inout  wire  [WIDTH-1:0] fd,
   input  logic             SLRD,
   input  logic             SLWR,
   input  logic             SLOE,
   input  logic             PKTEND,
   input  logic [1:0]       FIFOADDR,
   output logic             EMPTY_FLAG,
   output logic             FULL_FLAG,
   input  logic [WIDTH-1:0] host_tx_data,
   input  logic             host_tx_enable,
   input  logic             host_tx_last,
   output logic             host_tx_ready,
   output logic [WIDTH-1:0] host_rx_data,
   output logic             host_rx_enable,
   output logic             host_rx_last,
   input  logic             host_rx_ready,
   output logic [15:0]      zlp_count,
   output logic             overflow_err,
   output logic             underflow_err
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              PW      = AW + 1;
   localparam logic [1:0]      ADDR_RD = 2'(EP_RD / 2 - 1);
   localparam logic [1:0]      ADDR_WR = 2'(EP_WR / 2 - 1);
   localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0]   PKT_P   = PW'(PKT_WORDS);
   localparam logic [PW-1:0]   ONE_P   = PW'(1);

   logic [WIDTH-1:0] h2f_mem [DEPTH];
   logic [WIDTH-1:0] f2h_mem [DEPTH];
   logic [DEPTH-1:0] f_last_q;

   logic [PW-1:0] h_wp_q, h_wp_d, h_cp_q, h_cp_d, h_rp_q, h_rp_d;
   logic [PW-1:0] f_wp_q, f_wp_d, f_cp_q, f_cp_d, f_rp_q, f_rp_d;
   logic [PW-1:0] h_occ, h_staged_d, f_occ, f_staged_d;
   logic [AW-1:0] f_last_idx;

   logic sel_rd, sel_wr;
   logic h_accept, h_commit, h_pop_req, h_pop;
   logic f_wr_req, f_accept, f_ovf, f_pktend, f_commit, f_zlp, f_pop;

   logic        empty_q, full_q, ovf_q, udf_q;
   logic [15:0] zlp_q;

   logic             fd_oe;
   logic [WIDTH-1:0] fd_out;

   assign sel_rd = (FIFOADDR == ADDR_RD);
   assign sel_wr = (FIFOADDR == ADDR_WR);

   // Host -> FPGA: the host stream fills staged space, SLRD drains the committed region.
   always_comb begin
      h_occ      = h_wp_q - h_rp_q;
      h_accept   = host_tx_enable && (h_occ < DEPTH_P);
      h_wp_d     = h_wp_q + (h_accept ? ONE_P : '0);
      h_staged_d = h_wp_d - h_cp_q;
      h_commit   = h_accept && (host_tx_last || (h_staged_d == PKT_P));
      h_cp_d     = h_commit ? h_wp_d : h_cp_q;
      h_pop_req  = !SLRD && sel_rd;
      h_pop      = h_pop_req && (h_cp_q != h_rp_q);
      h_rp_d     = h_rp_q + (h_pop ? ONE_P : '0);
   end

   assign host_tx_ready = (h_occ < DEPTH_P);

   // An empty committed region drives zero so staged words never leak onto the bus.
   assign fd_oe  = reset_n && !SLOE && sel_rd;
   assign fd_out = (h_cp_q != h_rp_q) ? h2f_mem[h_rp_q[AW-1:0]] : '0;
   assign fd     = fd_oe ? fd_out : {WIDTH{1'bz}};

   // FPGA -> host: SLWR stages words, auto-commit or PKTEND publishes them to the host stream.
   always_comb begin
      f_occ      = f_wp_q - f_rp_q;
      f_wr_req   = !SLWR && sel_wr;
      f_accept   = f_wr_req && (f_occ < DEPTH_P);
      f_ovf      = f_wr_req && !f_accept;
      f_wp_d     = f_wp_q + (f_accept ? ONE_P : '0);
      f_staged_d = f_wp_d - f_cp_q;
      f_pktend   = !PKTEND && sel_wr;
      f_commit   = (f_staged_d == PKT_P) || (f_pktend && (f_staged_d != '0));
      f_zlp      = f_pktend && (f_staged_d == '0);
      f_cp_d     = f_commit ? f_wp_d : f_cp_q;
      f_last_idx = f_wp_d[AW-1:0] - AW'(1);
      f_pop      = (f_cp_q != f_rp_q) && host_rx_ready;
      f_rp_d     = f_rp_q + (f_pop ? ONE_P : '0);
   end

   assign host_rx_enable = (f_cp_q != f_rp_q);
   assign host_rx_data   = f2h_mem[f_rp_q[AW-1:0]];
   assign host_rx_last   = host_rx_enable && f_last_q[f_rp_q[AW-1:0]];

   // Flags sample the pointers left by the previous edge, giving the one-cycle FX2 flag lag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_wp_q  <= '0;
         h_cp_q  <= '0;
         h_rp_q  <= '0;
         f_wp_q  <= '0;
         f_cp_q  <= '0;
         f_rp_q  <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         zlp_q   <= '0;
      end else begin
         h_wp_q  <= h_wp_d;
         h_cp_q  <= h_cp_d;
         h_rp_q  <= h_rp_d;
         f_wp_q  <= f_wp_d;
         f_cp_q  <= f_cp_d;
         f_rp_q  <= f_rp_d;
         empty_q <= (h_cp_q == h_rp_q);
         full_q  <= (f_occ == DEPTH_P);
         if (h_pop_req && !h_pop) begin
            udf_q <= 1'b1;
         end
         if (f_ovf) begin
            ovf_q <= 1'b1;
         end
         if (f_zlp && (zlp_q != 16'hFFFF)) begin
            zlp_q <= zlp_q + 16'd1;
         end
      end
   end

   // Storage and last-word marks need no reset: pointers gate every read after reset.
   always_ff @(posedge clk) begin
      if (h_accept) begin
         h2f_mem[h_wp_q[AW-1:0]] <= host_tx_data;
      end
      if (f_accept) begin
         f2h_mem[f_wp_q[AW-1:0]] <= fd;
         f_last_q[f_wp_q[AW-1:0]] <= 1'b0;
      end
      if (f_commit) begin
         f_last_q[f_last_idx] <= 1'b1;
      end
   end

   assign EMPTY_FLAG    = empty_q;
   assign FULL_FLAG     = full_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;
   assign zlp_count     = zlp_q;

endmodule
